icrc: RTL and testbench



---
 rtl/icrc.sv | 185 ++++++++++++++++++
 tb/tb_icrc.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icrc.sv
// ---------------------------------------------------------------------------
// icrc -- RoCEv2 invariant CRC (ICRC) inserter, one register stage deep.
//
// Packets arrive on m_axis_rx starting at the IPv4 header (IHL=5). The final
// four valid bytes of each packet are the ICRC field. The block computes a
// CRC-32 over eight 0xFF bytes followed by every packet byte except the ICRC
// field, with the variant fields (ECN/DSCP, TTL, IPv4 checksum, UDP checksum,
// BTH resv8a) replaced by 0xFF. It writes the result, least-significant byte
// first, into the ICRC field of the last beat. Every other byte, and all
// tkeep and tlast values, pass through unchanged.
//
// Handshake: a beat moves on either port when tvalid and tready are both high
// at a rising edge of nclk. The source holds tdata/tkeep/tlast stable while
// tvalid=1 and tready=0. An input beat accepted in one cycle is presented on
// m_axis_tx in the next cycle.
//
// Ports
//   nclk              clock, rising edge
//   nresetn           asynchronous reset, ACTIVE HIGH despite the name
//   m_axis_rx_*       AXI4-Stream slave: tdata, tkeep, tlast, tvalid, tready
//   m_axis_tx_*       AXI4-Stream master: tdata, tkeep, tlast, tvalid, tready
// ---------------------------------------------------------------------------
module icrc #(
  parameter int DATA_BITS = 512
) (
  input  logic                   nclk,
  input  logic                   nresetn,
  input  logic [DATA_BITS-1:0]   m_axis_rx_tdata,
  input  logic [DATA_BITS/8-1:0] m_axis_rx_tkeep,
  input  logic                   m_axis_rx_tlast,
  input  logic                   m_axis_rx_tvalid,
  output logic                   m_axis_rx_tready,
  output logic [DATA_BITS-1:0]   m_axis_tx_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tx_tkeep,
  output logic                   m_axis_tx_tlast,
  output logic                   m_axis_tx_tvalid,
  input  logic                   m_axis_tx_tready
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  // One byte through the reflected CRC-32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // The eight leading 0xFF bytes are packet-independent, so they are folded
  // into the start state instead of being clocked through on every packet.
  function automatic logic [31:0] crc_prefix(input logic [31:0] seed);
    logic [31:0] r;
    r = seed;
    for (int k = 0; k < 8; k++) begin
      r = crc_byte(r, 8'hFF);
    end
    return r;
  endfunction

  localparam logic [31:0] CRC_START = crc_prefix(32'hFFFFFFFF);

  // Variant header bytes, located by their offset in the first beat.
  function automatic logic masked_byte(input int i);
    return (i == 1) || (i == 8) || (i == 10) || (i == 11) ||
           (i == 26) || (i == 27) || (i == 32);
  endfunction

  logic [31:0]           crc_q, crc_d;
  logic                  first_q, first_d;   // next accepted beat starts a packet
  logic [DATA_BITS-1:0]  tx_data_q, tx_data_d;
  logic [KEEP_BITS-1:0]  tx_keep_q, tx_keep_d;
  logic                  tx_last_q, tx_last_d;
  logic                  tx_valid_q, tx_valid_d;

  int                    n_valid;
  logic                  icrc_en;
  logic [7:0]            byte_in;
  logic [31:0]           crc_run;
  logic [31:0]           crc_fin;
  logic [1:0]            icrc_idx;
  logic [DATA_BITS-1:0]  out_data;
  logic                  accept;

  // Reset must hold tready low even though the output stage is empty.
  assign m_axis_rx_tready = !nresetn && (!tx_valid_q || m_axis_tx_tready);
  assign accept           = m_axis_rx_tvalid && m_axis_rx_tready;

  // Per-beat CRC contribution and ICRC insertion.
  always_comb begin
    n_valid  = 0;
    icrc_en  = 1'b0;
    byte_in  = 8'h00;
    crc_run  = crc_q;
    crc_fin  = 32'h0;
    icrc_idx = 2'd0;
    out_data = m_axis_rx_tdata;

    for (int i = 0; i < KEEP_BITS; i++) begin
      if (m_axis_rx_tkeep[i]) n_valid++;
    end

    // A last beat with fewer than four bytes carries no ICRC field; it is
    // forwarded untouched.
    icrc_en = m_axis_rx_tlast && (n_valid >= 4);

    for (int i = 0; i < KEEP_BITS; i++) begin
      byte_in = m_axis_rx_tdata[8*i +: 8];
      if (first_q && masked_byte(i)) byte_in = 8'hFF;
      if (m_axis_rx_tkeep[i] && !(icrc_en && (i >= n_valid - 4))) begin
        crc_run = crc_byte(crc_run, byte_in);
      end
    end
    crc_fin = ~crc_run;

    for (int i = 0; i < KEEP_BITS; i++) begin
      if (icrc_en && (i >= n_valid - 4) && (i < n_valid)) begin
        icrc_idx = 2'(i - n_valid + 4);
        case (icrc_idx)
          2'd0:    out_data[8*i +: 8] = crc_fin[7:0];
          2'd1:    out_data[8*i +: 8] = crc_fin[15:8];
          2'd2:    out_data[8*i +: 8] = crc_fin[23:16];
          default: out_data[8*i +: 8] = crc_fin[31:24];
        endcase
      end
    end
  end

  // Next-state for the running CRC and the output register stage.
  always_comb begin
    crc_d      = crc_q;
    first_d    = first_q;
    tx_data_d  = tx_data_q;
    tx_keep_d  = tx_keep_q;
    tx_last_d  = tx_last_q;
    tx_valid_d = tx_valid_q;

    if (accept) begin
      if (m_axis_rx_tlast) begin
        crc_d   = CRC_START;
        first_d = 1'b1;
      end else begin
        crc_d   = crc_run;
        first_d = 1'b0;
      end
    end

    // The stage refills whenever it is empty or draining this cycle.
    if (m_axis_rx_tready) begin
      tx_valid_d = m_axis_rx_tvalid;
      if (m_axis_rx_tvalid) begin
        tx_data_d = out_data;
        tx_keep_d = m_axis_rx_tkeep;
        tx_last_d = m_axis_rx_tlast;
      end
    end
  end

  always_ff @(posedge nclk or posedge nresetn) begin
    if (nresetn) begin
      crc_q      <= CRC_START;
      first_q    <= 1'b1;
      tx_data_q  <= '0;
      tx_keep_q  <= '0;
      tx_last_q  <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      crc_q      <= crc_d;
      first_q    <= first_d;
      tx_data_q  <= tx_data_d;
      tx_keep_q  <= tx_keep_d;
      tx_last_q  <= tx_last_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign m_axis_tx_tdata  = tx_data_q;
  assign m_axis_tx_tkeep  = tx_keep_q;
  assign m_axis_tx_tlast  = tx_last_q;
  assign m_axis_tx_tvalid = tx_valid_q;

endmodule

// File: tb/tb_icrc.sv
// ---------------------------------------------------------------------------
// tb_icrc -- self-checking bench for icrc.
//
// Packets are byte queues. A table-driven CRC-32 over the whole packet gives
// the expected ICRC, and the expected output beats are cut from the packet
// with that ICRC written in. The traffic runner drives input beats (with
// optional random gaps) and random output backpressure, and records every
// output handshake. Each test task compares the recorded beats itself.
// ---------------------------------------------------------------------------
module tb_icrc;

  localparam int DW = 512;
  localparam int KW = DW / 8;

  // ---------------- clock / reset ----------------
  logic          nclk = 1'b0;
  logic          nresetn;
  logic [DW-1:0] rx_tdata;
  logic [KW-1:0] rx_tkeep;
  logic          rx_tlast;
  logic          rx_tvalid;
  logic          rx_tready;
  logic [DW-1:0] tx_tdata;
  logic [KW-1:0] tx_tkeep;
  logic          tx_tlast;
  logic          tx_tvalid;
  logic          tx_tready;

  always #5 nclk = ~nclk;

  icrc #(.DATA_BITS(DW)) dut (
    .nclk             (nclk),
    .nresetn          (nresetn),
    .m_axis_rx_tdata  (rx_tdata),
    .m_axis_rx_tkeep  (rx_tkeep),
    .m_axis_rx_tlast  (rx_tlast),
    .m_axis_rx_tvalid (rx_tvalid),
    .m_axis_rx_tready (rx_tready),
    .m_axis_tx_tdata  (tx_tdata),
    .m_axis_tx_tkeep  (tx_tkeep),
    .m_axis_tx_tlast  (tx_tlast),
    .m_axis_tx_tvalid (tx_tvalid),
    .m_axis_tx_tready (tx_tready)
  );

  // ---------------- bookkeeping ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int stall_errs   = 0;

  logic [31:0]   crc_tab [256];
  logic [7:0]    pkt [$];

  logic [DW-1:0] in_data_q [$];
  logic [KW-1:0] in_keep_q [$];
  logic          in_last_q [$];
  logic [DW-1:0] exp_q [$];
  logic [KW-1:0] exp_keep_q [$];
  logic          exp_last_q [$];
  logic [DW-1:0] got_data_q [$];
  logic [KW-1:0] got_keep_q [$];
  logic          got_last_q [$];
  int            got_cyc_q [$];
  int            acc_cyc_q [$];

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [31:0] model_icrc();
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 8; i++) c = crc_tab[c[7:0] ^ 8'hFF] ^ (c >> 8);
    for (int i = 0; i < pkt.size() - 4; i++) begin
      b = pkt[i];
      if (i == 1 || i == 8 || i == 10 || i == 11 || i == 26 || i == 27 || i == 32) b = 8'hFF;
      c = crc_tab[c[7:0] ^ b] ^ (c >> 8);
    end
    return ~c;
  endfunction

  task automatic build_pkt(input int len);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    pkt[0] = 8'h45;
    pkt[1] = 8'h02;
    pkt[2] = 8'(len >> 8);
    pkt[3] = 8'(len);
  endtask

  task automatic build_three_beat();
    build_pkt(168);
    pkt[2]   = 8'h04;
    pkt[3]   = 8'h2C;
    pkt[164] = 8'h85;
    pkt[165] = 8'hA1;
    pkt[166] = 8'h90;
    pkt[167] = 8'hF0;
  endtask

  // Appends the current packet to the input and expected-output queues.
  task automatic enqueue_packet();
    int            len;
    int            last_n;
    int            n;
    logic [31:0]   c;
    logic [7:0]    ob [$];
    logic [DW-1:0] d;
    logic [DW-1:0] od;
    logic [KW-1:0] k;
    len    = pkt.size();
    last_n = (len % KW == 0) ? KW : (len % KW);
    ob     = pkt;
    if (last_n >= 4) begin
      c = model_icrc();
      for (int i = 0; i < 4; i++) ob[len - 4 + i] = c[8*i +: 8];
    end
    for (int s = 0; s < len; s += KW) begin
      n  = (len - s < KW) ? (len - s) : KW;
      d  = '0;
      od = '0;
      k  = '0;
      for (int j = 0; j < n; j++) begin
        d[8*j +: 8]  = pkt[s + j];
        od[8*j +: 8] = ob[s + j];
        k[j]         = 1'b1;
      end
      in_data_q.push_back(d);
      in_keep_q.push_back(k);
      in_last_q.push_back(s + KW >= len);
      exp_q.push_back(od);
      exp_keep_q.push_back(k);
      exp_last_q.push_back(s + KW >= len);
    end
  endtask

  task automatic clear_queues();
    in_data_q.delete();  in_keep_q.delete();  in_last_q.delete();
    exp_q.delete();      exp_keep_q.delete(); exp_last_q.delete();
  endtask

  // ---------------- driver / collector ----------------
  // Entered and left at 1 time unit after a rising edge.
  task automatic run_traffic(input bit rand_ready, input bit rand_gaps);
    int            bi;
    int            nb;
    int            budget;
    bit            acc;
    bit            held_v;
    logic [DW-1:0] held_d;
    logic [KW-1:0] held_k;
    logic          held_l;
    nb     = in_data_q.size();
    bi     = 0;
    budget = nb * 20 + 50;
    held_v = 1'b0;
    held_d = '0;
    held_k = '0;
    held_l = 1'b0;
    stall_errs = 0;
    got_data_q.delete(); got_keep_q.delete(); got_last_q.delete();
    got_cyc_q.delete();  acc_cyc_q.delete();
    rx_tvalid = 1'b0;
    while (got_data_q.size() < nb && budget > 0) begin
      budget--;
      if (!rx_tvalid && bi < nb) rx_tvalid = rand_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rx_tvalid) begin
        rx_tdata = in_data_q[bi];
        rx_tkeep = in_keep_q[bi];
        rx_tlast = in_last_q[bi];
      end else begin
        rx_tdata = rand_wide();
        rx_tkeep = KW'(rand_wide());
        rx_tlast = 1'($urandom);
      end
      tx_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      acc = rx_tvalid && rx_tready;
      if (acc) acc_cyc_q.push_back(cyc);
      if (held_v && (tx_tvalid !== 1'b1 || tx_tdata !== held_d ||
                     tx_tkeep !== held_k || tx_tlast !== held_l)) stall_errs++;
      held_v = tx_tvalid && !tx_tready;
      held_d = tx_tdata;
      held_k = tx_tkeep;
      held_l = tx_tlast;
      if (tx_tvalid === 1'b1 && tx_tready) begin
        got_data_q.push_back(tx_tdata);
        got_keep_q.push_back(tx_tkeep);
        got_last_q.push_back(tx_tlast);
        got_cyc_q.push_back(cyc);
      end
      @(posedge nclk);
      #1;
      cyc++;
      if (acc) begin
        bi++;
        rx_tvalid = 1'b0;
      end
    end
    rx_tvalid = 1'b0;
    tx_tready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nresetn = 1'b1;
    repeat (2) @(posedge nclk);
    #1;
    tests_run++;
    if (tx_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_tx_tvalid: got %b, expected 0", tx_tvalid);
    end
    tests_run++;
    if (rx_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rx_tready: got %b, expected 0", rx_tready);
    end
    tests_run++;
    if (tx_tdata !== '0 || tx_tkeep !== '0 || tx_tlast !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_tx_fields: got keep=%h last=%b data=%h, expected all zero", tx_tkeep, tx_tlast, tx_tdata);
    end
    nresetn = 1'b0;
    #4;
    tests_run++;
    if (rx_tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_rx_tready: got %b, expected 1", rx_tready);
    end
    @(posedge nclk);
    #1;
  endtask

  task automatic test_three_beat();
    clear_queues();
    build_three_beat();
    enqueue_packet();
    run_traffic(1'b0, 1'b0);
    tests_run++;
    if (got_data_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL three_beat_count: got %0d beats, expected %0d", got_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      tests_run++;
      if (got_data_q[i] !== exp_q[i] || got_keep_q[i] !== exp_keep_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        tests_failed++;
        $display("FAIL three_beat beat %0d: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                 i, got_keep_q[i], got_last_q[i], got_data_q[i], exp_keep_q[i], exp_last_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < acc_cyc_q.size() && i < got_cyc_q.size(); i++) begin
      tests_run++;
      if (got_cyc_q[i] !== acc_cyc_q[i] + 1) begin
        tests_failed++;
        $display("FAIL three_beat_latency beat %0d: got output cycle %0d, expected %0d", i, got_cyc_q[i], acc_cyc_q[i] + 1);
      end
    end
  endtask

  task automatic test_field_mask();
    logic [31:0] crc_orig;
    logic [31:0] crc_got;
    clear_queues();
    build_three_beat();
    crc_orig = model_icrc();
    pkt[1]  = pkt[1] ^ 8'h5A;
    pkt[8]  = pkt[8] ^ 8'h3C;
    pkt[10] = pkt[10] ^ 8'hA5;
    pkt[11] = pkt[11] ^ 8'h0F;
    pkt[26] = pkt[26] ^ 8'hC3;
    pkt[27] = pkt[27] ^ 8'h81;
    pkt[32] = pkt[32] ^ 8'h7E;
    enqueue_packet();
    run_traffic(1'b0, 1'b0);
    tests_run++;
    if (got_data_q.size() !== 3) begin
      tests_failed++;
      $display("FAIL field_mask_count: got %0d beats, expected 3", got_data_q.size());
    end else begin
      crc_got = got_data_q[2][8*36 +: 32];
      tests_run++;
      if (crc_got !== crc_orig) begin
        tests_failed++;
        $display("FAIL field_mask_icrc: got %h, expected %h", crc_got, crc_orig);
      end
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (got_data_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL field_mask beat %0d: got %h, expected %h", i, got_data_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_queues();
    build_three_beat();
    enqueue_packet();
    run_traffic(1'b1, 1'b1);
    tests_run++;
    if (got_data_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL backpressure_count: got %0d beats, expected %0d", got_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      tests_run++;
      if (got_data_q[i] !== exp_q[i] || got_keep_q[i] !== exp_keep_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        tests_failed++;
        $display("FAIL backpressure beat %0d: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                 i, got_keep_q[i], got_last_q[i], got_data_q[i], exp_keep_q[i], exp_last_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (stall_errs !== 0) begin
      tests_failed++;
      $display("FAIL backpressure_stable: got %0d changes while stalled, expected 0", stall_errs);
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    build_pkt(64);
    enqueue_packet();
    build_three_beat();
    enqueue_packet();
    run_traffic(1'b0, 1'b0);
    tests_run++;
    if (got_data_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL back_to_back_count: got %0d beats, expected %0d", got_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      tests_run++;
      if (got_data_q[i] !== exp_q[i] || got_keep_q[i] !== exp_keep_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        tests_failed++;
        $display("FAIL back_to_back beat %0d: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                 i, got_keep_q[i], got_last_q[i], got_data_q[i], exp_keep_q[i], exp_last_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (acc_cyc_q.size() !== 4 || acc_cyc_q[3] - acc_cyc_q[0] !== 3) begin
      tests_failed++;
      $display("FAIL back_to_back_no_bubble: got %0d accepts spanning %0d cycles, expected 4 spanning 3",
               acc_cyc_q.size(), (acc_cyc_q.size() > 0) ? (acc_cyc_q[acc_cyc_q.size() - 1] - acc_cyc_q[0]) : -1);
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_queues();
    build_three_beat();
    enqueue_packet();
    rx_tdata  = in_data_q[0];
    rx_tkeep  = in_keep_q[0];
    rx_tlast  = in_last_q[0];
    rx_tvalid = 1'b1;
    @(posedge nclk);
    #1;
    rx_tvalid = 1'b0;
    nresetn   = 1'b1;
    #1;
    tests_run++;
    if (tx_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_async_clear: got tx_tvalid=%b, expected 0", tx_tvalid);
    end
    repeat (2) @(posedge nclk);
    #1;
    nresetn = 1'b0;
    @(posedge nclk);
    #1;
    run_traffic(1'b0, 1'b0);
    tests_run++;
    if (got_data_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL reset_mid_count: got %0d beats, expected %0d", got_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      tests_run++;
      if (got_data_q[i] !== exp_q[i] || got_keep_q[i] !== exp_keep_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        tests_failed++;
        $display("FAIL reset_mid beat %0d: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                 i, got_keep_q[i], got_last_q[i], got_data_q[i], exp_keep_q[i], exp_last_q[i], exp_q[i]);
      end
    end
  endtask

  // A packet whose last beat has only 2 bytes passes untouched, and the
  // following packet still gets a correct ICRC.
  task automatic test_short_last();
    clear_queues();
    build_pkt(66);
    enqueue_packet();
    build_three_beat();
    enqueue_packet();
    run_traffic(1'b0, 1'b0);
    tests_run++;
    if (got_data_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL short_last_count: got %0d beats, expected %0d", got_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      tests_run++;
      if (got_data_q[i] !== exp_q[i] || got_keep_q[i] !== exp_keep_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        tests_failed++;
        $display("FAIL short_last beat %0d: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                 i, got_keep_q[i], got_last_q[i], got_data_q[i], exp_keep_q[i], exp_last_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 4; r++) begin
      clear_queues();
      for (int p = 0; p < 3; p++) begin
        len = $urandom_range(40, 260);
        if (len % KW >= 1 && len % KW <= 3) len += 4;
        build_pkt(len);
        enqueue_packet();
      end
      run_traffic(1'b1, 1'b1);
      tests_run++;
      if (got_data_q.size() !== exp_q.size()) begin
        tests_failed++;
        $display("FAIL random_count round %0d: got %0d beats, expected %0d", r, got_data_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
        tests_run++;
        if (got_data_q[i] !== exp_q[i] || got_keep_q[i] !== exp_keep_q[i] || got_last_q[i] !== exp_last_q[i]) begin
          tests_failed++;
          $display("FAIL random round %0d beat %0d: got keep=%h last=%b data=%h, expected keep=%h last=%b data=%h",
                   r, i, got_keep_q[i], got_last_q[i], got_data_q[i], exp_keep_q[i], exp_last_q[i], exp_q[i]);
        end
      end
      tests_run++;
      if (stall_errs !== 0) begin
        tests_failed++;
        $display("FAIL random_stable round %0d: got %0d changes while stalled, expected 0", r, stall_errs);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
    nresetn   = 1'b1;
    rx_tvalid = 1'b0;
    rx_tdata  = '0;
    rx_tkeep  = '0;
    rx_tlast  = 1'b0;
    tx_tready = 1'b1;

    test_reset();
    test_three_beat();
    test_field_mask();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_short_last();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
